// File: rtl/fifo_pkg.sv
// Shared types and constants for the async_fifo read-side stream adapter.
package fifo_pkg;

    // Default width of FIFO and stream data.
    localparam int DEF_DATA_WIDTH = 64;

    // Output buffer depth: two entries cover the one-cycle FIFO read latency
    // so reads can be issued without looking at m_ready combinationally.
    localparam int SKID_DEPTH = 2;

    // Width of the buffer occupancy count (0..SKID_DEPTH).
    localparam int OCC_W = 2;

    // Adapter mode: normal streaming or draining/discarding the FIFO.
    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } rd_state_t;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry output buffer. Entry 0 is always the head, so the stream data
// and valid come straight from registers.
module rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_valid,
    output logic [OCC_W-1:0]      occupancy,
    output logic [OCC_W-1:0]      clear_count
);

    localparam logic [OCC_W-1:0] FULL = OCC_W'(SKID_DEPTH);

    logic [DATA_WIDTH-1:0] entry0;
    logic [DATA_WIDTH-1:0] entry1;
    logic [OCC_W-1:0]      occ;

    assign head_data   = entry0;
    assign head_valid  = (occ != '0);
    assign occupancy   = occ;
    // Entries held right now are the ones a clear this cycle throws away.
    assign clear_count = occ;

    // Push appends at the tail, pop shifts entry 1 into the head; clear wins.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            entry0 <= '0;
            entry1 <= '0;
            occ    <= '0;
        end else if (clear) begin
            entry0 <= '0;
            occ    <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == '0) entry0 <= push_data;
                    else           entry1 <= push_data;
                    occ <= occ + 1'b1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    occ    <= occ - 1'b1;
                end
                2'b11: begin
                    // Occupancy unchanged; the head advances.
                    if (occ == FULL) begin
                        entry0 <= entry1;
                        entry1 <= push_data;
                    end else begin
                        entry0 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter for async_fifo: turns rd_en/empty/dout (one-cycle read
// latency) into a registered valid/ready stream, with a flush that drains
// and discards the FIFO, plus saturating delivered/discarded beat counters.
//
// Handshake: a beat transfers on a rd_clk edge where m_valid && m_ready;
// once m_valid is high it stays high with m_data unchanged until that
// transfer happens. m_ready never reaches fifo_rd_en or m_data through
// combinational logic other than the credit check.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_rd_empty,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    input  logic                  flush,
    output logic                  flush_busy,
    output logic                  flush_done,
    output logic [CNT_WIDTH-1:0]  beat_count,
    output logic [CNT_WIDTH-1:0]  drop_count,
    output rd_state_t             state
);

    rd_state_t          state_next;
    logic               inflight;
    logic               rd_req;
    logic               pop;
    logic               push;
    logic               clear;
    logic               done_next;
    logic [OCC_W-1:0]   occupancy;
    logic [OCC_W-1:0]   clear_count;
    logic [2:0]         credit;
    logic [2:0]         entry_drop;
    logic [1:0]         drop_inc;
    logic [CNT_WIDTH:0] drop_sum;

    rd_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .rd_clk     (rd_clk),
        .rd_rst     (rd_rst),
        .push       (push),
        .push_data  (fifo_dout),
        .pop        (pop),
        .clear      (clear),
        .head_data  (m_data),
        .head_valid (m_valid),
        .occupancy  (occupancy),
        .clear_count(clear_count)
    );

    assign pop        = m_valid && m_ready;
    assign flush_busy = (state == FLUSH);
    // The FIFO shares rd_rst, so never strobe it while reset is asserted.
    assign fifo_rd_en = rd_req && !rd_rst;

    // Entries that will be held after this cycle if nothing new is read.
    assign credit     = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, pop};
    // On flush entry: held entries not popped this cycle plus the arriving beat.
    assign entry_drop = {1'b0, clear_count} + {2'b00, inflight} - {2'b00, pop};

    // Mode control, read credit and discard accounting.
    always_comb begin
        state_next = state;
        rd_req     = 1'b0;
        push       = 1'b0;
        clear      = 1'b0;
        done_next  = 1'b0;
        drop_inc   = 2'd0;
        case (state)
            RUN: begin
                rd_req = !fifo_rd_empty && (credit < 3'd2);
                if (flush) begin
                    clear      = 1'b1;
                    drop_inc   = entry_drop[1:0];
                    state_next = FLUSH;
                end else begin
                    push = inflight;
                end
            end
            FLUSH: begin
                rd_req   = !fifo_rd_empty;
                drop_inc = {1'b0, inflight};
                if (fifo_rd_empty && !inflight) begin
                    state_next = RUN;
                    done_next  = 1'b1;
                end
            end
            default: state_next = RUN;
        endcase
    end

    assign drop_sum = {1'b0, drop_count} + (CNT_WIDTH + 1)'(drop_inc);

    // State register, read-return tracking and the flush-complete pulse.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state      <= RUN;
            inflight   <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            state      <= state_next;
            inflight   <= fifo_rd_en;
            flush_done <= done_next;
        end
    end

    // Saturating delivered and discarded beat counters.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            beat_count <= '0;
            drop_count <= '0;
        end else begin
            if (pop && (beat_count != '1)) beat_count <= beat_count + 1'b1;
            if (drop_sum[CNT_WIDTH]) drop_count <= '1;
            else                     drop_count <= drop_sum[CNT_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO, expected-beat queue, table of
// streaming/flush cases plus hand-written latency, backpressure, reset and
// counter-saturation sequences.
module tb_fifo_rd_stream;
    import fifo_pkg::*;

    localparam int DW = 64;
    localparam int CW = 32;

    // ---------------- clock / reset ----------------
    logic rd_clk = 1'b0;
    logic rd_rst;
    always #5 rd_clk = ~rd_clk;

    // ---------------- main DUT ----------------
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_dout;
    logic          fifo_rd_empty;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          flush;
    logic          flush_busy;
    logic          flush_done;
    logic [CW-1:0] beat_count;
    logic [CW-1:0] drop_count;
    rd_state_t     dut_state;

    fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_rd_en(fifo_rd_en),
        .fifo_dout(fifo_dout), .fifo_rd_empty(fifo_rd_empty),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .flush(flush), .flush_busy(flush_busy), .flush_done(flush_done),
        .beat_count(beat_count), .drop_count(drop_count), .state(dut_state)
    );

    // ---------------- narrow-counter DUT ----------------
    logic       sat_rd_en;
    logic [7:0] sat_dout;
    logic       sat_empty;
    logic [7:0] sat_m_data;
    logic       sat_m_valid;
    logic       sat_m_ready;
    logic       sat_flush;
    logic       sat_busy;
    logic       sat_done;
    logic [2:0] sat_beat;
    logic [2:0] sat_drop;
    rd_state_t  sat_state;

    fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(3)) dut_sat (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_rd_en(sat_rd_en),
        .fifo_dout(sat_dout), .fifo_rd_empty(sat_empty),
        .m_data(sat_m_data), .m_valid(sat_m_valid), .m_ready(sat_m_ready),
        .flush(sat_flush), .flush_busy(sat_busy), .flush_done(sat_done),
        .beat_count(sat_beat), .drop_count(sat_drop), .state(sat_state)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int rd_en_empty_viol = 0;
    int rd_en_pulses = 0;
    int done_pulses = 0;
    int sat_hs = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural async_fifo read port: one-cycle read latency, empty
    // reflects writes made during the previous cycle.
    always @(posedge rd_clk) begin
        if (rd_rst) begin
            fifo_rd_empty <= 1'b1;
            fifo_dout     <= '0;
        end else begin
            if (fifo_rd_en && fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
            fifo_rd_empty <= (fifo_q.size() == 0);
        end
    end

    // Scoreboard/monitor, sampled mid-cycle.
    always @(negedge rd_clk) begin
        if (!rd_rst) begin
            if (fifo_rd_en && fifo_rd_empty) rd_en_empty_viol++;
            if (fifo_rd_en) rd_en_pulses++;
            if (flush_done) done_pulses++;
            if (sat_m_valid && sat_m_ready) sat_hs++;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected none", m_data);
                end else begin
                    check("beat_data", m_data, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic push_beats(input int n, input bit expect_out);
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = {$urandom, $urandom};
            fifo_q.push_back(d);
            if (expect_out) exp_q.push_back(d);
        end
    endtask

    function automatic logic ready_for(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 2) == 0;
            2:       return 1'($urandom_range(1, 0));
            default: return 1'b0;
        endcase
    endfunction

    task automatic drain(input int mode, input int budget);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < budget) begin
            m_ready = ready_for(mode, cyc);
            tick();
            cyc++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
        m_ready = 1'b0;
        repeat (3) tick();
    endtask

    // ---------------- case table ----------------
    typedef struct {
        int n_beats;
        int ready_mode;   // 0 always, 1 alternate, 2 random, 3 never
        bit do_flush;
        int exp_beats;
        int exp_drops;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] first;
        logic [CW-1:0] base_b;
        logic [CW-1:0] base_d;
        int seen;
        int lat;

        vecs[0] = '{1024, 1, 1'b0, 1024, 0};
        vecs[1] = '{8,    3, 1'b1, 0,    8};
        vecs[2] = '{3,    0, 1'b0, 3,    0};
        vecs[3] = '{40,   2, 1'b0, 40,   0};
        vecs[4] = '{6,    3, 1'b1, 0,    6};
        vecs[5] = '{1,    0, 1'b0, 1,    0};

        rd_rst = 1'b1;
        m_ready = 1'b0;
        flush = 1'b0;
        sat_dout = 8'hA5;
        sat_empty = 1'b1;
        sat_m_ready = 1'b0;
        sat_flush = 1'b0;
        repeat (3) tick();

        // Reset values.
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, '0);
        check("rst_flush_busy", flush_busy, 1'b0);
        check("rst_flush_done", flush_done, 1'b0);
        check("rst_beat_count", beat_count, '0);
        check("rst_drop_count", drop_count, '0);
        check("rst_state", dut_state, RUN);
        check("rst_rd_en", fifo_rd_en, 1'b0);
        rd_rst = 1'b0;
        tick();

        // First-beat latency: m_valid two cycles after empty deasserts.
        m_ready = 1'b1;
        push_beats(5, 1'b1);
        seen = -1;
        lat = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge rd_clk);
            if (seen < 0 && !fifo_rd_empty) seen = c;
            if (m_valid) begin
                lat = c - seen;
                break;
            end
        end
        check("first_valid_latency", 64'(lat), 64'd2);
        drain(0, 100);
        check("lat_beat_count", beat_count, 32'd5);
        check("lat_drop_count", drop_count, 32'd0);

        // Backpressure: head held stable, only two reads issued.
        m_ready = 1'b0;
        rd_en_pulses = 0;
        push_beats(5, 1'b1);
        first = exp_q[0];
        repeat (3) tick();
        for (int c = 0; c < 10; c++) begin
            @(negedge rd_clk);
            check("bp_m_valid", m_valid, 1'b1);
            check("bp_m_data", m_data, first);
        end
        check("bp_rd_en_count", 64'(rd_en_pulses), 64'd2);
        tick();
        drain(0, 100);
        check("bp_beat_count", beat_count, 32'd10);

        // Table-driven streaming and flush cases.
        for (int i = 0; i < 6; i++) begin
            base_b = beat_count;
            base_d = drop_count;
            if (!vecs[i].do_flush) begin
                push_beats(vecs[i].n_beats, 1'b1);
                drain(vecs[i].ready_mode, vecs[i].n_beats * 4 + 64);
            end else begin
                m_ready = 1'b0;
                push_beats(vecs[i].n_beats, 1'b0);
                repeat (6) tick();
                done_pulses = 0;
                flush = 1'b1;
                tick();
                flush = 1'b0;
                check("flush_busy_on", flush_busy, 1'b1);
                check("flush_m_valid", m_valid, 1'b0);
                // A second pulse while already flushing must be ignored.
                flush = 1'b1;
                tick();
                flush = 1'b0;
                for (int c = 0; c < 200 && flush_busy; c++) tick();
                check("flush_exit", flush_busy, 1'b0);
                repeat (2) tick();
                check("flush_done_pulses", 64'(done_pulses), 64'd1);
                check("flush_state", dut_state, RUN);
            end
            check("tbl_beat_count", beat_count, base_b + 32'(vecs[i].exp_beats));
            check("tbl_drop_count", drop_count, base_d + 32'(vecs[i].exp_drops));
        end

        // Reset mid-stream with data buffered and a read in flight.
        m_ready = 1'b0;
        push_beats(5, 1'b1);
        repeat (3) tick();
        #1;
        rd_rst = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        #1;
        check("mid_rst_m_valid", m_valid, 1'b0);
        check("mid_rst_m_data", m_data, '0);
        check("mid_rst_beat_count", beat_count, '0);
        check("mid_rst_drop_count", drop_count, '0);
        check("mid_rst_flush_busy", flush_busy, 1'b0);
        check("mid_rst_rd_en", fifo_rd_en, 1'b0);
        repeat (2) tick();
        rd_rst = 1'b0;
        tick();
        push_beats(2, 1'b1);
        drain(0, 100);
        repeat (5) tick();
        check("post_rst_beat_count", beat_count, 32'd2);
        check("post_rst_drop_count", drop_count, 32'd0);

        // Counter saturation on the 3-bit instance: 10 beats, count holds at 7.
        sat_hs = 0;
        sat_m_ready = 1'b1;
        sat_empty = 1'b0;
        repeat (10) tick();
        sat_empty = 1'b1;
        repeat (6) tick();
        check("sat_handshakes", 64'(sat_hs), 64'd10);
        check("sat_beat_count", sat_beat, 3'd7);
        check("sat_drop_count", sat_drop, 3'd0);

        check("rd_en_while_empty", 64'(rd_en_empty_viol), 64'd0);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
